// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic {
    OWN_CPU    = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  // Width needed to count 0..max_burst inclusive
  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Bounded-burst round-robin arbiter sharing one data-memory port between
// the CPU (m0) and the loader (m1), with a registered read response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned   BW        = burst_cnt_w(MAX_BURST);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  owner_e              owner_q, owner_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic                rsp_pend_q, rsp_pend_d;
  owner_e              rsp_sel_q, rsp_sel_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic                gnt0_c, gnt1_c, keep_c;
  owner_e              winner_c, gnt_own_c;

  // Tie resolution. burst_cnt==0 only occurs after reset, where the
  // non-owner (CPU, since owner resets to loader) must take the first tie.
  always_comb begin
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    keep_c   = (burst_q != '0) && (burst_q < BURST_MAX);
    winner_c = owner_q;
    if (!keep_c) begin
      if (owner_q == OWN_CPU) winner_c = OWN_LOADER;
      else                    winner_c = OWN_CPU;
    end
    if (!rst) begin
      if (m0_req && m1_req) begin
        gnt0_c = (winner_c == OWN_CPU);
        gnt1_c = (winner_c == OWN_LOADER);
      end else begin
        gnt0_c = m0_req;
        gnt1_c = m1_req;
      end
    end
  end

  // Memory port mux; m0 values are parked on the bus when idle
  always_comb begin
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    mem_we    = 1'b0;
    if (gnt1_c) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
    end else if (gnt0_c) begin
      mem_we    = m0_we;
    end
  end

  // Next-state: ownership/burst tracking and read response capture
  always_comb begin
    owner_d    = owner_q;
    burst_d    = burst_q;
    rsp_pend_d = 1'b0;
    rsp_sel_d  = rsp_sel_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    gnt_own_c  = gnt1_c ? OWN_LOADER : OWN_CPU;
    if (gnt0_c || gnt1_c) begin
      if (gnt_own_c == owner_q) begin
        burst_d = (burst_q == BURST_MAX) ? BURST_MAX : BW'(burst_q + 1'b1);
      end else begin
        owner_d = gnt_own_c;
        burst_d = BW'(1);
      end
      rsp_pend_d = !mem_we;
      rsp_sel_d  = gnt_own_c;
      if (gnt0_c && !m0_we) rdata0_d = mem_rdata;
      if (gnt1_c && !m1_we) rdata1_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_LOADER;
      burst_q    <= '0;
      rsp_pend_q <= 1'b0;
      rsp_sel_q  <= OWN_CPU;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_sel_q  <= rsp_sel_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign m0_gnt    = gnt0_c;
  assign m1_gnt    = gnt1_c;
  assign m0_rvalid = rsp_pend_q && (rsp_sel_q == OWN_CPU);
  assign m1_rvalid = rsp_pend_q && (rsp_sel_q == OWN_LOADER);
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus multi-cycle sequences
// against a small behavioural word memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [4:0]  exp_ctl;   // {gnt0, gnt1, mem_we, rvalid0, rvalid1}
    logic [31:0] exp_rd0, exp_rd1;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic r0, input logic w0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [4:0] ctl,
                              input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = r; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.exp_ctl = ctl; v.exp_rd0 = rd0; v.exp_rd1 = rd1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  vec_t vecs [10];

  logic [31:0] h_addr [5];
  logic [31:0] h_data [5];
  logic        h_we   [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'd4;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Reset, single read, loader write/read, then a contended handover
    vecs[0] = mk(1, 1, 0, 32'h100, 0, 1, 1, 32'h104, 5, 5'b00000, 0, 0);
    vecs[1] = mk(0, 1, 0, 32'h100, 0, 0, 0, 0,       0, 5'b10000, 0, 0);
    vecs[2] = mk(0, 0, 0, 0,       0, 0, 0, 0,       0, 5'b00010, 4, 0);
    vecs[3] = mk(0, 0, 0, 0,       0, 1, 1, 32'h104, 5, 5'b01100, 4, 0);
    vecs[4] = mk(0, 0, 0, 0,       0, 1, 0, 32'h104, 0, 5'b01000, 4, 0);
    vecs[5] = mk(0, 0, 0, 0,       0, 0, 0, 0,       0, 5'b00001, 4, 5);
    vecs[6] = mk(0, 1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 5'b01000, 4, 5);
    vecs[7] = mk(0, 1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 5'b01001, 4, 5);
    vecs[8] = mk(0, 1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 5'b10001, 4, 5);
    vecs[9] = mk(0, 0, 0, 0,       0, 0, 0, 0,       0, 5'b00010, 4, 5);

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i),
            32'({m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid}), 32'(vecs[i].exp_ctl));
      check($sformatf("vec%0d_rd0", i), m0_rdata, vecs[i].exp_rd0);
      check($sformatf("vec%0d_rd1", i), m1_rdata, vecs[i].exp_rd1);
      next_cycle();
    end

    // Continuous contention from reset: m0 x4, m1 x4, m0 x4
    reset_pulse();
    drive(1, 0, 32'h100, 0, 1, 0, 32'h104, 0);
    begin
      logic exp_g0, prev_g0;
      prev_g0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
        exp_g0 = !(i >= 4 && i < 8);
        @(negedge clk);
        check($sformatf("cont%0d_gnt", i), 32'({m0_gnt, m1_gnt}), 32'({exp_g0, !exp_g0}));
        if (i > 0)
          check($sformatf("cont%0d_rv", i), 32'({m0_rvalid, m1_rvalid}), 32'({prev_g0, !prev_g0}));
        prev_g0 = exp_g0;
        next_cycle();
      end
    end

    // Loader alone saturates its burst; CPU joining is granted at once
    reset_pulse();
    drive(0, 0, 0, 0, 1, 0, 32'h104, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("alone%0d_gnt", i), 32'({m0_gnt, m1_gnt}), 32'b01);
      next_cycle();
    end
    drive(1, 0, 32'h100, 0, 1, 0, 32'h104, 0);
    @(negedge clk);
    check("join_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
    next_cycle();

    // Reset raised late in a read-grant cycle cancels the response
    reset_pulse();
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rstmid_gnt", 32'(m0_gnt), 32'd1);
    rst = 1'b1;
    next_cycle();
    drive(1, 0, 32'h100, 0, 1, 0, 32'h104, 0);
    @(negedge clk);
    check("rstmid_ctl", 32'({m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid}), 32'd0);
    check("rstmid_rd0", m0_rdata, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_tie", 32'({m0_gnt, m1_gnt}), 32'b10);
    next_cycle();

    // Hold rule: loader waits with 0x108 while the CPU bursts
    reset_pulse();
    h_addr[0] = 32'h100; h_data[0] = 1; h_we[0] = 1;
    h_addr[1] = 32'h104; h_data[1] = 2; h_we[1] = 1;
    h_addr[2] = 32'h10C; h_data[2] = 4; h_we[2] = 1;
    h_addr[3] = 32'h110; h_data[3] = 5; h_we[3] = 1;
    h_addr[4] = 32'h100; h_data[4] = 0; h_we[4] = 0;
    begin
      int  idx0;
      int  m1_cyc;
      logic m1_done;
      idx0 = 0; m1_cyc = -1; m1_done = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (idx0 < 5) drive(1, h_we[idx0], h_addr[idx0], h_data[idx0],
                            !m1_done, 1, 32'h108, 3);
        else          drive(0, 0, 0, 0, !m1_done, 1, 32'h108, 3);
        @(negedge clk);
        if (m1_gnt && !m1_done) begin
          check("hold_addr", mem_addr, 32'h108);
          m1_cyc = cyc;
          m1_done = 1'b1;
        end
        if (m0_gnt) idx0++;
        next_cycle();
        if (idx0 == 5 && m1_done) break;
      end
      check("hold_done", 32'({m1_done, 3'(idx0)}), 32'({1'b1, 3'd5}));
      check("hold_wait", 32'(m1_cyc), 32'd4);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("hold_rv0", 32'(m0_rvalid), 32'd1);
      check("hold_rd0", m0_rdata, 32'd1);
      next_cycle();
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("image%0d", i), mem[(32'h100 >> 2) + i], 32'(i + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
